// File: rtl/add32_accumulator_pkg.sv
// Shared definitions for the add32 accumulator: default adder width and FSM state encoding.
package add32_accumulator_pkg;

  localparam int ADD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/csel_add32.sv
// W-bit carry-select adder with carry-in fixed at 0; returns the sum and the carry-out.
module csel_add32
  import add32_accumulator_pkg::*;
#(
  parameter int W = ADD_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int LO = W / 2;
  localparam int HI = W - LO;

  logic [LO:0] lo_sum;
  logic [HI:0] hi_sum0;
  logic [HI:0] hi_sum1;

  assign lo_sum  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]};
  // Both upper-half results are formed in parallel; the low carry picks one.
  assign hi_sum0 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
  assign hi_sum1 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]} + {{HI{1'b0}}, 1'b1};

  assign {cout, sum[W-1:LO]} = lo_sum[LO] ? hi_sum1 : hi_sum0;
  assign sum[LO-1:0]         = lo_sum[LO-1:0];

endmodule

// File: rtl/add32_accumulator.sv
// Streaming packet accumulator: sums W-bit operands, counts carry-outs, presents result on a valid/ready port.
// Define ACC_SAT_EN to clamp the sum to all-ones on the first carry of a packet (reported on out_sat).
module add32_accumulator
  import add32_accumulator_pkg::*;
#(
  parameter int W  = ADD_W,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic [CW-1:0] out_carries,
  output logic          out_sat
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  acc_state_t    state;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [W-1:0]  add_sum;
  logic          add_c;
  logic          accept;

  function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c, input logic inc);
    if (inc && (c != CNT_MAX)) return c + {{(CW-1){1'b0}}, 1'b1};
    return c;
  endfunction

  csel_add32 #(.W(W)) u_add (
    .a   (acc),
    .b   (in_data),
    .sum (add_sum),
    .cout(add_c)
  );

  assign in_ready = (state != ST_DONE) && !rst;
  assign accept   = in_valid && in_ready;

`ifdef ACC_SAT_EN
  logic sat;

  // Once clamped, the sum stays at all-ones until the packet completes.
  function automatic logic [W-1:0] acc_clamp(input logic [W-1:0] s, input logic c, input logic sat_now);
    if (c || sat_now) return '1;
    return s;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
`ifdef ACC_SAT_EN
      sat       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc       <= in_data;
            cnt       <= '0;
`ifdef ACC_SAT_EN
            sat       <= 1'b0;
`endif
            state     <= in_last ? ST_DONE : ST_ACC;
            out_valid <= in_last;
          end
        end
        ST_ACC: begin
          if (accept) begin
`ifdef ACC_SAT_EN
            acc <= acc_clamp(add_sum, add_c, sat);
            sat <= sat || add_c;
`else
            acc <= add_sum;
`endif
            cnt <= cnt_sat_inc(cnt, add_c);
            if (in_last) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_sum     = acc;
  assign out_carries = cnt;
`ifdef ACC_SAT_EN
  assign out_sat     = sat;
`else
  assign out_sat     = 1'b0;
`endif

endmodule
